// File: rtl/accum_cpu_pkg.sv
// Shared types for the multi-cycle accumulator CPU:
// opcodes, FSM states and instruction width helper.
package accum_cpu_pkg;

   localparam int OPC_W = 4;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDI = 4'h1,
      OP_LD  = 4'h2,
      OP_ST  = 4'h3,
      OP_ADD = 4'h4,
      OP_SUB = 4'h5,
      OP_AND = 4'h6,
      OP_OR  = 4'h7,
      OP_XOR = 4'h8,
      OP_JMP = 4'h9,
      OP_JZ  = 4'hA,
      OP_JC  = 4'hB,
      OP_IN  = 4'hC,
      OP_OUT = 4'hD,
      OP_SHL = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_WAIT_IN,
      S_WAIT_OUT,
      S_HALT
   } state_e;

   function automatic int instr_w(input int addr_w);
      return OPC_W + addr_w;
   endfunction

endpackage

// File: rtl/accum_cpu_alu.sv
// Combinational ALU: result and carry/borrow for
// load, arithmetic, logic and shift opcodes.
module accum_cpu_alu
   import accum_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  opcode_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] res,
   output logic              cy
);

   // Pick the operation; SUB carry is the borrow bit.
   always_comb begin
      res = a;
      cy  = 1'b0;
      case (op)
         OP_LDI, OP_LD: res = b;
         OP_ADD: {cy, res} = {1'b0, a} + {1'b0, b};
         OP_SUB: {cy, res} = {1'b0, a} - {1'b0, b};
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_SHL: {cy, res} = {a, 1'b0};
         default: ;
      endcase
   end

endmodule

// File: rtl/accum_cpu_mc.sv
// Multi-cycle accumulator CPU: fetch/execute FSM,
// flags, data memory and ready/valid stream ports.
module accum_cpu_mc
   import accum_cpu_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int DMEM_AW  = 4,
   localparam int INSTR_W = instr_w(ADDR_W)
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  acc,
   output logic               zero_flag,
   output logic               carry_flag,
   output logic               halted
);

   localparam int CW = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
   logic [DATA_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               z_q, z_d, c_q, c_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0]  dmem_q [2**DMEM_AW];
   logic               dmem_we;

   opcode_e            opc;
   logic [ADDR_W-1:0]  opnd;
   logic [DMEM_AW-1:0] dm_idx;
   logic [DATA_W-1:0]  dm_rd, imm, alu_b, alu_res;
   logic               alu_cy;

   assign opc    = opcode_e'(ir_q[INSTR_W-1:ADDR_W]);
   assign opnd   = ir_q[ADDR_W-1:0];
   assign dm_idx = opnd[DMEM_AW-1:0];
   assign dm_rd  = dmem_q[dm_idx];
   assign pc_inc = pc_q + ADDR_W'(1);
   assign alu_b  = (opc == OP_LDI) ? imm : dm_rd;

   // Immediate: zero-extend or truncate operand to DATA_W.
   always_comb begin
      imm = '0;
      imm[CW-1:0] = opnd[CW-1:0];
   end

   accum_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op  (opc),
      .a   (acc_q),
      .b   (alu_b),
      .res (alu_res),
      .cy  (alu_cy)
   );

   assign imem_req   = (state_q == S_FETCH) && !reset;
   assign imem_addr  = pc_q;
   assign in_ready   = (state_q == S_WAIT_IN);
   assign halted     = (state_q == S_HALT);
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign acc        = acc_q;
   assign zero_flag  = z_q;
   assign carry_flag = c_q;

   // Next-state, datapath updates and dmem write enable.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      acc_d       = acc_q;
      z_d         = z_q;
      c_d         = c_q;
      ir_d        = ir_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      dmem_we     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
            case (opc)
               OP_LDI, OP_LD, OP_AND, OP_OR, OP_XOR: begin
                  acc_d = alu_res;
                  z_d   = (alu_res == '0);
               end
               OP_ADD, OP_SUB, OP_SHL: begin
                  acc_d = alu_res;
                  z_d   = (alu_res == '0);
                  c_d   = alu_cy;
               end
               OP_ST:  dmem_we = 1'b1;
               OP_JMP: pc_d = opnd;
               OP_JZ:  if (z_q) pc_d = opnd;
               OP_JC:  if (c_q) pc_d = opnd;
               OP_IN: begin
                  pc_d    = pc_q;
                  state_d = S_WAIT_IN;
               end
               OP_OUT: begin
                  pc_d        = pc_q;
                  out_data_d  = acc_q;
                  out_valid_d = 1'b1;
                  state_d     = S_WAIT_OUT;
               end
               OP_HLT: begin
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end
               default: ;
            endcase
         end
         S_WAIT_IN: begin
            if (in_valid) begin
               acc_d   = in_data;
               z_d     = (in_data == '0);
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end
         end
         S_WAIT_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               pc_d        = pc_inc;
               state_d     = S_FETCH;
            end
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   // Architectural state with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         pc_q        <= '0;
         acc_q       <= '0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         ir_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         acc_q       <= acc_d;
         z_q         <= z_d;
         c_q         <= c_d;
         ir_q        <= ir_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Data memory write; contents survive reset.
   always_ff @(posedge clk) begin
      if (dmem_we) dmem_q[dm_idx] <= acc_q;
   end

endmodule

// File: tb/tb_accum_cpu_mc.sv
// Directed bench for accum_cpu_mc: ROM model with
// fetch stalls and an output-stream scoreboard.
module tb_accum_cpu_mc;

   localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, ST  = 4'h3;
   localparam logic [3:0] ADD = 4'h4, SUB = 4'h5, JMP = 4'h9;
   localparam logic [3:0] JZ  = 4'hA, JC  = 4'hB, IN  = 4'hC;
   localparam logic [3:0] OUT = 4'hD, SHL = 4'hE, HLT = 4'hF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [11:0] imem_rdata = '0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  acc;
   logic        zero_flag, carry_flag, halted;

   logic [11:0] rom [256];
   logic [7:0]  exp_q [$];
   int          stall_cfg = 0;
   int          wait_cnt = 0;
   int          checks = 0;
   int          failures = 0;

   accum_cpu_mc dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .acc        (acc),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] ins(input logic [3:0] op,
                                       input logic [7:0] a);
      return {op, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ROM responder: ack after stall_cfg idle request cycles.
   always @(negedge clk) begin
      imem_rdata = rom[imem_addr];
      if (imem_req) begin
         if (wait_cnt < stall_cfg) begin
            imem_ack = 1'b0;
            wait_cnt++;
         end else begin
            imem_ack = 1'b1;
            wait_cnt = 0;
         end
      end else begin
         imem_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   // Monitor: every accepted output word is checked in order.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected actual=%0h", out_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               failures++;
               $display("FAIL out_data actual=%0h expected=%0h",
                        out_data, e);
            end
         end
      end
   end

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = ins(NOP, 8'h00);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      int n;
      n = 0;
      while (!halted && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_halt"}, halted, 1'b1);
      chk({name, "_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      int n;
      clear_rom();
      @(negedge clk);
      // reset state
      chk("rst_req", imem_req, 1'b0);
      chk("rst_acc", acc, 8'h00);
      chk("rst_flags", {zero_flag, carry_flag}, 2'b00);
      chk("rst_out", {out_valid, out_data}, 9'h000);
      chk("rst_halt", halted, 1'b0);

      // 1: ADD with carry, JZ taken
      rom[0] = ins(LDI, 8'h7F);
      rom[1] = ins(ST,  8'h01);
      rom[2] = ins(LDI, 8'h81);
      rom[3] = ins(ADD, 8'h01);
      rom[4] = ins(JZ,  8'h20);
      rom[5] = ins(LDI, 8'hEE);
      rom[6] = ins(OUT, 8'h00);
      rom[7] = ins(HLT, 8'h00);
      rom[8'h20] = ins(OUT, 8'h00);
      rom[8'h21] = ins(HLT, 8'h00);
      exp_q.push_back(8'h00);
      do_reset();
      wait_halt("t1");
      chk("t1_acc", acc, 8'h00);
      chk("t1_zc", {zero_flag, carry_flag}, 2'b11);

      // 2: SUB borrow, JC taken, JZ not taken
      clear_rom();
      rom[0] = ins(LDI, 8'h03);
      rom[1] = ins(ST,  8'h02);
      rom[2] = ins(LDI, 8'h01);
      rom[3] = ins(SUB, 8'h02);
      rom[4] = ins(JC,  8'h40);
      rom[5] = ins(LDI, 8'hEE);
      rom[6] = ins(OUT, 8'h00);
      rom[7] = ins(HLT, 8'h00);
      rom[8'h40] = ins(OUT, 8'h00);
      rom[8'h41] = ins(JZ,  8'h50);
      rom[8'h42] = ins(LDI, 8'h11);
      rom[8'h43] = ins(OUT, 8'h00);
      rom[8'h44] = ins(HLT, 8'h00);
      rom[8'h50] = ins(LDI, 8'h77);
      rom[8'h51] = ins(OUT, 8'h00);
      rom[8'h52] = ins(HLT, 8'h00);
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'h11);
      do_reset();
      wait_halt("t2");
      chk("t2_acc", acc, 8'h11);
      chk("t2_zc", {zero_flag, carry_flag}, 2'b01);

      // 3: OUT backpressure
      clear_rom();
      rom[0] = ins(LDI, 8'h5A);
      rom[1] = ins(OUT, 8'h00);
      rom[2] = ins(LDI, 8'h33);
      rom[3] = ins(OUT, 8'h00);
      rom[4] = ins(HLT, 8'h00);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h33);
      out_ready = 1'b0;
      do_reset();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      for (int k = 0; k < 3; k++) begin
         chk("t3_valid", out_valid, 1'b1);
         chk("t3_data", out_data, 8'h5A);
         chk("t3_noreq", imem_req, 1'b0);
         if (k < 2) @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("t3_valid4", out_valid, 1'b1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("t3_drop", out_valid, 1'b0);
      chk("t3_fetch", {imem_req, imem_addr}, {1'b1, 8'h02});
      out_ready = 1'b1;
      wait_halt("t3");

      // 4: IN wait, nonzero then zero data
      clear_rom();
      rom[0] = ins(IN,  8'h00);
      rom[1] = ins(OUT, 8'h00);
      rom[2] = ins(IN,  8'h00);
      rom[3] = ins(OUT, 8'h00);
      rom[4] = ins(HLT, 8'h00);
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'h00);
      do_reset();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      for (int k = 0; k < 4; k++) begin
         chk("t4_ready", in_ready, 1'b1);
         if (k < 3) @(negedge clk);
      end
      @(posedge clk);
      #1 in_data = 8'hC3;
      in_valid = 1'b1;
      @(negedge clk);
      chk("t4_ready5", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("t4_acc", acc, 8'hC3);
      chk("t4_z", zero_flag, 1'b0);
      chk("t4_rdy_low", in_ready, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      chk("t4_ready_b", in_ready, 1'b1);
      @(posedge clk);
      #1 in_data = 8'h00;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("t4_acc0", acc, 8'h00);
      chk("t4_z0", zero_flag, 1'b1);
      wait_halt("t4");

      // 5: fetch stall, PC wrap, halt
      clear_rom();
      rom[0] = ins(JC,  8'h80);
      rom[1] = ins(LDI, 8'h80);
      rom[2] = ins(SHL, 8'h00);
      rom[3] = ins(JMP, 8'hFF);
      rom[8'hFF] = ins(NOP, 8'h00);
      rom[8'h80] = ins(LDI, 8'h05);
      rom[8'h81] = ins(OUT, 8'h00);
      rom[8'h82] = ins(HLT, 8'h00);
      exp_q.push_back(8'h05);
      stall_cfg = 2;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_stall", {imem_req, imem_addr}, {1'b1, 8'h00});
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(imem_req && imem_addr == 8'hFF) && n < 200);
      chk("t5_at_ff", imem_addr, 8'hFF);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(imem_req && imem_addr != 8'hFF) && n < 50);
      chk("t5_wrap", imem_addr, 8'h00);
      wait_halt("t5");
      chk("t5_acc", acc, 8'h05);
      chk("t5_zc", {zero_flag, carry_flag}, 2'b01);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("t5_halted", {halted, imem_req}, 2'b10);
      end
      stall_cfg = 0;

      // 6: async reset during WAIT_OUT
      clear_rom();
      rom[0] = ins(LDI, 8'h3C);
      rom[1] = ins(OUT, 8'h00);
      rom[2] = ins(HLT, 8'h00);
      out_ready = 1'b0;
      do_reset();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      chk("t6_valid", {out_valid, acc}, {1'b1, 8'h3C});
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_acc", acc, 8'h00);
      chk("t6_rst_pc", imem_addr, 8'h00);
      chk("t6_rst_req", imem_req, 1'b0);
      chk("t6_rst_data", out_data, 8'h00);
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(8'h3C);
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t6_first_req", {imem_req, imem_addr}, {1'b1, 8'h00});
      wait_halt("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/accum_cpu_mc.md
Name: accum_cpu_mc

Overview:
Parametrised multi-cycle accumulator processor. It is the successor to the single-cycle 8-bit accumulator core.
- Adds an explicit fetch/execute FSM with an instruction-memory handshake and an internal data memory.
- Adds zero and carry flags, conditional branches, and ready/valid I/O ports with backpressure.
- Sits between an external instruction ROM/RAM and streaming producer/consumer blocks.

Parameters:
- DATA_W, 8, accumulator / data-memory / I/O word width (>=2).
- ADDR_W, 8, PC and instruction operand width; PC wraps modulo 2**ADDR_W.
- DMEM_AW, 4, data-memory address width (<=ADDR_W); depth 2**DMEM_AW, indexed by operand[DMEM_AW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH, forced 0 while reset is high.
- imem_addr  out  ADDR_W  fetch address, equal to PC.
- imem_ack  in  1  instruction valid this cycle.
- imem_rdata  in  4+ADDR_W  instruction: [MSB:ADDR_W]=opcode, [ADDR_W-1:0]=operand.
- in_data  in  DATA_W  input stream data.
- in_valid  in  1  input stream valid.
- in_ready  out  1  high only in WAIT_IN.
- out_data  out  DATA_W  registered output word.
- out_valid  out  1  registered; high only in WAIT_OUT.
- out_ready  in  1  consumer accepts.
- acc  out  DATA_W  accumulator value.
- zero_flag  out  1  Z flag.
- carry_flag  out  1  C flag.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async): state=FETCH, PC=0, acc=0, Z=0, C=0, out_data=0, out_valid=0, IR=0. Data memory is not reset.
- FSM states: FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT.
- FETCH: imem_req=1, imem_addr=PC held stable. On imem_ack, IR<=imem_rdata and go to EXEC. Ack may arrive in the same cycle as req.
- EXEC: one cycle. PC<=PC+1 (wraps) unless a jump is taken or the opcode changes state. Default next state is FETCH.
- Minimum rate is 2 cycles per instruction.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc<=operand, zero-extended or truncated to DATA_W.
  - 2 LD: acc<=dmem[op].
  - 3 ST: dmem[op]<=acc.
  - 4 ADD: {C,acc}<=acc+dmem[op].
  - 5 SUB: acc<=acc-dmem[op]; C=1 on borrow (acc<dmem, unsigned).
  - 6 AND, 7 OR, 8 XOR: with dmem[op].
  - 9 JMP: PC<=op.
  - A JZ: PC<=op if Z, else PC+1.
  - B JC: PC<=op if C, else PC+1.
  - C IN: go to WAIT_IN, PC unchanged.
  - D OUT: out_data<=acc, out_valid<=1, go to WAIT_OUT, PC unchanged.
  - E SHL: {C,acc}<={acc,1'b0}.
  - F HLT: go to HALT.
- Flag rules:
  - Z<=(new acc==0) on every acc write (LDI, LD, ALU ops, SHL, IN).
  - C is written only by ADD, SUB, SHL.
  - Flags are otherwise held.
- Branches test the flags as they stand at the start of EXEC.
- WAIT_IN: in_ready=1. On in_valid&&in_ready: acc<=in_data, update Z, PC<=PC+1, go to FETCH.
- WAIT_OUT: out_data held stable. On out_ready: out_valid<=0, PC<=PC+1, go to FETCH.
  - out_valid drops the cycle after the transfer.
  - No second transfer occurs per OUT.
- HALT: terminal. imem_req=0, in_ready=0, halted=1. Exit only by reset.
- Reset mid-operation (any state, including WAIT_OUT with out_valid=1): all outputs take their reset values immediately. The first request after release is at PC=0.
- PC wrap: PC=2**ADDR_W-1 followed by a non-jump instruction gives PC=0.
- Operand bits above DMEM_AW are ignored for dmem access.

Decomposition:
- Package accum_cpu_pkg holds:
  - opcode enum (4-bit);
  - FSM state enum;
  - OPC_W=4 constant;
  - function computing INSTR_W=OPC_W+ADDR_W.
- One natural sub-module: accum_cpu_alu. It is combinational: opcode, acc and operand in; result and carry out.
- FSM, PC, flags and dmem live in the top module.

Test Plan:
1. ADD with carry (DATA_W=8): LDI 0x7F; ST 0x1; LDI 0x81; ADD 0x1; JZ 0x20 -> acc=0x00, Z=1, C=1, next imem_addr=0x20.
2. SUB borrow: LDI 0x03; ST 0x2; LDI 0x01; SUB 0x2; JC 0x40 -> acc=0xFE, C=1, Z=0, branch taken to 0x40. Also JZ 0x50 not taken -> PC+1.
3. OUT backpressure: LDI 0x5A; OUT, with out_ready low for 3 cycles then high 1 cycle -> out_valid high for exactly 4 cycles, out_data=0x5A stable, imem_req=0 throughout, then fetch from OUT address+1.
4. IN wait: IN with in_valid low for 4 cycles, then in_data=0xC3 valid -> in_ready high for all 5 cycles, acc=0xC3 and Z=0 the next cycle. Repeat with in_data=0x00 -> Z=1.
5. Fetch stall, wrap and halt: imem_ack delayed 2 cycles -> imem_addr stable, no IR change. JMP 0xFF then NOP -> imem_addr=0x00. HLT -> halted=1, imem_req=0 for 20 cycles.
6. Async reset asserted mid-cycle during WAIT_OUT -> out_valid, acc and PC go to 0 before the next clock edge. After release, first imem_req has imem_addr=0x00.
